// File: rtl/mm_stream_if.sv
// Element stream from the transmit side into the MM block.
//   tx_valid : in_data/col_end/row_end carry a valid element
//   in_data  : element value
//   col_end  : element is the last of its row
//   row_end  : element is the last of the matrix
//   busy     : MM stall; no transfer while high
// A transfer happens on a rising edge with tx_valid=1 and busy=0.
interface mm_stream_if #(
  parameter int DATA_W = 8
);
  logic              tx_valid;
  logic [DATA_W-1:0] in_data;
  logic              col_end;
  logic              row_end;
  logic              busy;

  modport master (output tx_valid, in_data, col_end, row_end, input busy);
  modport slave  (input tx_valid, in_data, col_end, row_end, output busy);
endinterface

// File: rtl/mm_stream_tx.sv
// Transmit end of the MM matrix input stream. For each job it walks NUM_MAT
// matrices (A, then B): it reads a row count and per-row column counts from a
// sync-read shape memory and the elements from a sync-read element memory,
// and presents them one by one to MM, holding while MM asserts busy.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   start             one-cycle pulse, begins a job when idle
//   data_base         element address of A's first element
//   shape_base        shape address of A's row-count entry
//   mem_addr/rdata    element memory; rdata valid one cycle after addr
//   shape_addr/rdata  shape memory; rdata valid one cycle after addr
//   tx                element stream to MM (master side)
//   active            job in progress
//   done              one-cycle pulse at job end
//   err               job ended on a zero row/column count; held until start
//   next_data_addr    element address after the last consumed element
//   next_shape_addr   shape address after the last consumed entry
module mm_stream_tx #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 20,
  parameter int SHP_AW  = 20,
  parameter int NUM_MAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] data_base,
  input  logic [SHP_AW-1:0] shape_base,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [SHP_AW-1:0] shape_addr,
  input  logic [3:0]        shape_rdata,
  mm_stream_if.master       tx,
  output logic              active,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] next_data_addr,
  output logic [SHP_AW-1:0] next_shape_addr
);

  typedef enum logic [2:0] {
    IDLE, RD_ROWS, RD_COLS, FETCH, SEND, GAP, FINISH, FAIL
  } state_t;

  localparam int MAT_W = (NUM_MAT > 1) ? $clog2(NUM_MAT) : 1;
  localparam logic [MAT_W-1:0] MAT_LAST = MAT_W'(NUM_MAT - 1);

  state_t           state;
  logic             rows_ph;   // second cycle of RD_ROWS: row count on shape_rdata
  logic [3:0]       row_cnt;
  logic [3:0]       col_cnt;
  logic [3:0]       row_idx;
  logic [3:0]       col_idx;
  logic [MAT_W-1:0] mat_idx;
  logic             last_col;

  // Index of the element being fetched compared with its row length.
  assign last_col = (col_idx == col_cnt - 4'd1);

  // NOTE: every register here uses non-blocking assignments so that all of
  // them update together from the same pre-edge values; blocking ones would
  // make results depend on statement order inside the block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      rows_ph         <= 1'b0;
      row_cnt         <= '0;
      col_cnt         <= '0;
      row_idx         <= '0;
      col_idx         <= '0;
      mat_idx         <= '0;
      mem_addr        <= '0;
      shape_addr      <= '0;
      tx.tx_valid     <= 1'b0;
      tx.in_data      <= '0;
      tx.col_end      <= 1'b0;
      tx.row_end      <= 1'b0;
      active          <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      next_data_addr  <= '0;
      next_shape_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Both address buses start driving immediately so the first
            // element word is already waiting by the time FETCH is reached.
            mem_addr   <= data_base;
            shape_addr <= shape_base;
            active     <= 1'b1;
            err        <= 1'b0;
            mat_idx    <= '0;
            rows_ph    <= 1'b0;
            state      <= RD_ROWS;
          end
        end

        RD_ROWS: begin
          if (!rows_ph) begin
            // The row-count address is presented this cycle; step on to the
            // first column-count entry so its word arrives right behind it.
            shape_addr <= shape_addr + SHP_AW'(1);
            rows_ph    <= 1'b1;
          end else begin
            rows_ph <= 1'b0;
            row_cnt <= shape_rdata;
            row_idx <= '0;
            if (shape_rdata == 4'd0) begin
              err    <= 1'b1;
              done   <= 1'b1;
              active <= 1'b0;
              state  <= FAIL;
            end else begin
              state <= RD_COLS;
            end
          end
        end

        RD_COLS: begin
          // The entry read here has been addressed for at least one cycle on
          // every path into this state, so its word is valid now.
          col_cnt    <= shape_rdata;
          col_idx    <= '0;
          shape_addr <= shape_addr + SHP_AW'(1);
          if (shape_rdata == 4'd0) begin
            err    <= 1'b1;
            done   <= 1'b1;
            active <= 1'b0;
            state  <= FAIL;
          end else begin
            state <= FETCH;
          end
        end

        FETCH: begin
          tx.in_data  <= mem_rdata;
          tx.col_end  <= last_col;
          tx.row_end  <= last_col && (row_idx == row_cnt - 4'd1);
          tx.tx_valid <= 1'b1;
          // Advance now so the next word is read while this one is offered.
          mem_addr    <= mem_addr + ADDR_W'(1);
          state       <= SEND;
        end

        SEND: begin
          if (!tx.busy) begin
            tx.tx_valid <= 1'b0;
            tx.col_end  <= 1'b0;
            tx.row_end  <= 1'b0;
            if (!tx.col_end) begin
              col_idx <= col_idx + 4'd1;
              state   <= FETCH;
            end else if (!tx.row_end) begin
              row_idx <= row_idx + 4'd1;
              state   <= RD_COLS;
            end else if (mat_idx != MAT_LAST) begin
              mat_idx <= mat_idx + MAT_W'(1);
              state   <= GAP;
            end else begin
              done   <= 1'b1;
              active <= 1'b0;
              state  <= FINISH;
            end
          end
        end

        GAP: begin
          if (!tx.busy) begin
            rows_ph <= 1'b0;
            state   <= RD_ROWS;
          end
        end

        FINISH, FAIL: begin
          done            <= 1'b0;
          next_data_addr  <= mem_addr;
          next_shape_addr <= shape_addr;
          state           <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_stream_tx.sv
// Directed bench for mm_stream_tx: sync-read memory models, a transfer
// monitor, and one linear sequence of jobs with hand-computed expectations.
module tb_mm_stream_tx;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 20;
  localparam int SHP_AW = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] data_base = '0;
  logic [SHP_AW-1:0] shape_base = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [SHP_AW-1:0] shape_addr;
  logic [3:0]        shape_rdata;
  logic              active, done, err;
  logic [ADDR_W-1:0] next_data_addr;
  logic [SHP_AW-1:0] next_shape_addr;

  mm_stream_if #(.DATA_W(DATA_W)) mm_if ();

  mm_stream_tx #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SHP_AW(SHP_AW), .NUM_MAT(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .data_base(data_base), .shape_base(shape_base),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .shape_addr(shape_addr), .shape_rdata(shape_rdata),
    .tx(mm_if.master),
    .active(active), .done(done), .err(err),
    .next_data_addr(next_data_addr), .next_shape_addr(next_shape_addr)
  );

  always #5 clk = ~clk;

  logic [7:0] emem [0:255];
  logic [3:0] smem [0:63];

  always @(posedge clk) begin
    mem_rdata   <= emem[mem_addr[7:0]];
    shape_rdata <= smem[shape_addr[5:0]];
  end

  // Transfer monitor.
  int         cyc = 0;
  logic [7:0] got_d [$];
  logic       got_c [$];
  logic       got_r [$];
  int         xfer_cyc [$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         stall2 = 0;
  int         hold_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_d = '0;
  logic       prev_c = 1'b0;
  logic       prev_r = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mm_if.tx_valid && !mm_if.busy) begin
      got_d.push_back(mm_if.in_data);
      got_c.push_back(mm_if.col_end);
      got_r.push_back(mm_if.row_end);
      xfer_cyc.push_back(cyc);
    end
    if (mm_if.tx_valid && mm_if.busy && mm_if.in_data == 8'd2) stall2 <= stall2 + 1;
    if (prev_stall && (!mm_if.tx_valid || mm_if.in_data != prev_d ||
                       mm_if.col_end != prev_c || mm_if.row_end != prev_r))
      hold_err <= hold_err + 1;
    prev_stall <= mm_if.tx_valid && mm_if.busy;
    prev_d     <= mm_if.in_data;
    prev_c     <= mm_if.col_end;
    prev_r     <= mm_if.row_end;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic start_job(input logic [ADDR_W-1:0] db, input logic [SHP_AW-1:0] sb);
    @(negedge clk);
    data_base  = db;
    shape_base = sb;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_elem(input logic [7:0] v, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (mm_if.tx_valid && mm_if.in_data == v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Transfers since index n0 must be n values counting up from first.
  task automatic check_seq(input string tag, input int n0, input int n, input int first);
    check({tag, "_count"}, got_d.size() - n0, n);
    for (int i = 0; i < n && n0 + i < got_d.size(); i++)
      check($sformatf("%s_d%0d", tag, i), {24'd0, got_d[n0 + i]}, first + i);
  endtask

  function automatic logic [15:0] col_mask(input int n0, input int n);
    logic [15:0] m = '0;
    for (int i = 0; i < n && n0 + i < got_c.size(); i++) m[i] = got_c[n0 + i];
    return m;
  endfunction

  function automatic logic [15:0] row_mask(input int n0, input int n);
    logic [15:0] m = '0;
    for (int i = 0; i < n && n0 + i < got_r.size(); i++) m[i] = got_r[n0 + i];
    return m;
  endfunction

  task automatic load_std();
    // A: 2 rows of 3; B: 3 rows of 2. Elements 1..12 from address 16.
    smem[4] = 4'd2; smem[5] = 4'd3; smem[6] = 4'd3;
    smem[7] = 4'd3; smem[8] = 4'd2; smem[9] = 4'd2; smem[10] = 4'd2;
    for (int i = 0; i < 12; i++) emem[16 + i] = 8'(i + 1);
  endtask

  initial begin
    bit ok;
    bit flag;
    int n0, d0, s0, h0, fall_cyc;

    for (int i = 0; i < 256; i++) emem[i] = 8'hEE;
    for (int i = 0; i < 64; i++) smem[i] = 4'd0;
    mm_if.busy = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_addr", {12'd0, mem_addr}, 0);
    check("rst_shape_addr", {12'd0, shape_addr}, 0);
    check("rst_flags", {26'd0, mm_if.tx_valid, mm_if.col_end, mm_if.row_end, active, done, err}, 0);
    check("rst_next", {12'd0, next_data_addr | next_shape_addr}, 0);
    rst = 1'b1;

    // Job 1: standard shapes, no stall; first element five cycles after start.
    load_std();
    n0 = got_d.size(); d0 = done_cnt;
    start_job(20'd16, 20'd4);
    check("t1_active", active, 1);
    repeat (3) @(negedge clk);
    check("t1_lat_pre", mm_if.tx_valid, 0);
    @(negedge clk);
    check("t1_lat_first", {mm_if.tx_valid, mm_if.in_data}, {1'b1, 8'd1});
    wait_done(200, ok);
    check("t1_done_seen", ok, 1);
    check("t1_tx_after", mm_if.tx_valid, 0);
    @(negedge clk);
    check_seq("t1", n0, 12, 1);
    check("t1_col_end", col_mask(n0, 12), 16'h0AA4);
    check("t1_row_end", row_mask(n0, 12), 16'h0820);
    check("t1_done_width", done_cnt - d0, 1);
    if (got_d.size() > n0) check("t1_done_lat", done_cyc - xfer_cyc[xfer_cyc.size() - 1], 1);
    check("t1_next_data", {12'd0, next_data_addr}, 28);
    check("t1_next_shape", {12'd0, next_shape_addr}, 11);
    check("t1_end_flags", {active, err}, 0);

    // Job 2: MM stalls 4 cycles on element 2; a start pulse mid-job is ignored.
    n0 = got_d.size(); s0 = stall2; h0 = hold_err;
    start_job(20'd16, 20'd4);
    wait_elem(8'd2, 50, ok);
    check("t2_elem2_seen", ok, 1);
    mm_if.busy = 1'b1;
    data_base  = 20'd200;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    mm_if.busy = 1'b0;
    wait_done(200, ok);
    check("t2_done_seen", ok, 1);
    @(negedge clk);
    check_seq("t2", n0, 12, 1);
    check("t2_stall_cycles", stall2 - s0, 4);
    check("t2_hold_stable", hold_err - h0, 0);
    check("t2_next_data", {12'd0, next_data_addr}, 28);

    // Job 3: busy held through the A->B gap for 10 cycles.
    n0 = got_d.size();
    start_job(20'd16, 20'd4);
    wait_elem(8'd6, 60, ok);
    check("t3_elem6_seen", ok, 1);
    @(posedge clk);
    #1 mm_if.busy = 1'b1;
    flag = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (mm_if.tx_valid) flag = 1'b0;
    end
    fall_cyc = cyc;
    mm_if.busy = 1'b0;
    check("t3_gap_idle", flag, 1);
    wait_done(200, ok);
    check("t3_done_seen", ok, 1);
    @(negedge clk);
    check_seq("t3", n0, 12, 1);
    if (got_d.size() >= n0 + 7) check("t3_b_after_busy", xfer_cyc[n0 + 6] > fall_cyc, 1);

    // Job 4: ragged A (3 then 1 columns), B is a single element.
    smem[4] = 4'd2; smem[5] = 4'd3; smem[6] = 4'd1; smem[7] = 4'd1; smem[8] = 4'd1;
    for (int i = 0; i < 5; i++) emem[16 + i] = 8'(8'hA0 + i);
    n0 = got_d.size();
    start_job(20'd16, 20'd4);
    wait_done(200, ok);
    check("t4_done_seen", ok, 1);
    @(negedge clk);
    check_seq("t4", n0, 5, 8'hA0);
    check("t4_col_end", col_mask(n0, 5), 16'h001C);
    check("t4_row_end", row_mask(n0, 5), 16'h0018);
    check("t4_next_data", {12'd0, next_data_addr}, 21);
    check("t4_next_shape", {12'd0, next_shape_addr}, 9);

    // Job 5: second row of A has zero columns -> error after 3 elements.
    smem[4] = 4'd2; smem[5] = 4'd3; smem[6] = 4'd0;
    n0 = got_d.size(); d0 = done_cnt;
    start_job(20'd16, 20'd4);
    wait_done(200, ok);
    check("t5_done_seen", ok, 1);
    check("t5_err_at_done", err, 1);
    flag = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (mm_if.tx_valid) flag = 1'b0;
    end
    check("t5_quiet", flag, 1);
    check_seq("t5", n0, 3, 8'hA0);
    check("t5_done_width", done_cnt - d0, 1);
    check("t5_err_held", {err, active}, 2'b10);
    check("t5_next_data", {12'd0, next_data_addr}, 19);
    check("t5_next_shape", {12'd0, next_shape_addr}, 7);

    // Job 6: reset during B, then a fresh job from new bases.
    load_std();
    start_job(20'd16, 20'd4);
    check("t6_err_cleared", err, 0);
    wait_elem(8'd8, 60, ok);
    check("t6_elem8_seen", ok, 1);
    rst = 1'b0;
    #1;
    check("t6_rst_addr", {12'd0, mem_addr | next_data_addr}, 0);
    check("t6_rst_shape", {12'd0, shape_addr | next_shape_addr}, 0);
    check("t6_rst_flags", {18'd0, mm_if.in_data, mm_if.tx_valid, mm_if.col_end,
                           mm_if.row_end, active, done, err}, 0);
    @(negedge clk);
    rst = 1'b1;
    smem[40] = 4'd1; smem[41] = 4'd2; smem[42] = 4'd1; smem[43] = 4'd1;
    for (int i = 0; i < 3; i++) emem[100 + i] = 8'(8'h31 + i);
    n0 = got_d.size();
    start_job(20'd100, 20'd40);
    check("t6_new_bases", {mem_addr[7:0], 2'b00, shape_addr[5:0]}, {8'd100, 2'b00, 6'd40});
    wait_done(200, ok);
    check("t6_done_seen", ok, 1);
    @(negedge clk);
    check_seq("t6", n0, 3, 8'h31);
    check("t6_next_data", {12'd0, next_data_addr}, 103);
    check("t6_next_shape", {12'd0, next_shape_addr}, 44);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
